line_window3x3: RTL and testbench

LINE_WINDOW3X3 -- requirements
Module: line_window3x3

---
 rtl/line_window3x3.sv | 119 +++++++++++
 tb/tb_line_window3x3.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_window3x3.sv
// 3x3 sliding window over a raster pixel stream, built from two line buffers and
// three 3-entry shift rows. A window is emitted once the centre is at least one pixel in from the top and left edges.
module line_window3x3 #(
  parameter int BITWIDTH = 8,
  parameter int COLS     = 320,
  parameter int ROWS     = 240
) (
  input  logic                      clkMain,
  input  logic                      rstMain,
  input  logic                      frame_start,
  input  logic                      in_valid,
  input  logic [3*BITWIDTH-1:0]     in_data,
  output logic                      out_valid,
  output logic [27*BITWIDTH-1:0]    out_window,
  output logic [$clog2(COLS):0]     out_x,
  output logic [$clog2(ROWS):0]     out_y,
  output logic                      frame_done
);
  localparam int PW = 3 * BITWIDTH;
  localparam int XW = $clog2(COLS) + 1;
  localparam int YW = $clog2(ROWS) + 1;
  localparam int AW = $clog2(COLS);
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  logic [XW-1:0] x_q, x_d, pos_x;
  logic [YW-1:0] y_q, y_d, pos_y;
  logic [PW-1:0] win_q [9];
  logic [PW-1:0] win_d [9];
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;
  logic [XW-1:0] out_x_q, out_x_d;
  logic [YW-1:0] out_y_q, out_y_d;

  // lb0 holds the previous row, lb1 the row before that; neither is reset.
  logic [PW-1:0] lb0_mem [COLS];
  logic [PW-1:0] lb1_mem [COLS];
  logic [PW-1:0] lb0_rd, lb1_rd;
  logic [AW-1:0] lb_idx;

  always_comb begin
    pos_x        = frame_start ? '0 : x_q;
    pos_y        = frame_start ? '0 : y_q;
    lb_idx       = pos_x[AW-1:0];
    lb0_rd       = lb0_mem[lb_idx];
    lb1_rd       = lb1_mem[lb_idx];
    x_d          = x_q;
    y_d          = y_q;
    win_d        = win_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    if (in_valid) begin
      if (pos_x == X_LAST) begin
        x_d = '0;
        y_d = (pos_y == Y_LAST) ? '0 : pos_y + 1'b1;
      end else begin
        x_d = pos_x + 1'b1;
        y_d = pos_y;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]     = win_q[r*3+1];
        win_d[r*3 + 1] = win_q[r*3+2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = in_data;
      // Gating on x>=2 also keeps columns left over from the previous row out.
      out_valid_d  = (pos_x >= X_TWO) && (pos_y >= Y_TWO);
      frame_done_d = (pos_x == X_LAST) && (pos_y == Y_LAST);
      if (out_valid_d) begin
        out_x_d = pos_x - 1'b1;
        out_y_d = pos_y - 1'b1;
      end
    end else if (frame_start) begin
      x_d = '0;
      y_d = '0;
    end
  end

  always_ff @(posedge clkMain) begin
    if (rstMain) begin
      x_q          <= '0;
      y_q          <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
    end
  end

  always_ff @(posedge clkMain) begin
    if (in_valid && !rstMain) begin
      lb1_mem[lb_idx] <= lb0_rd;
      lb0_mem[lb_idx] <= in_data;
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++) out_window[k*PW +: PW] = win_q[k];
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
endmodule

// File: tb/tb_line_window3x3.sv
// Bench for line_window3x3 on an 8x6 frame where every pixel carries p=y*8+x in R, G and B.
// Valid pixels push the expected window and the cycle it must appear in; a negedge monitor pops and compares.
module tb_line_window3x3;
  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int PW   = 24;
  localparam int WW   = 216;
  localparam int XW   = 4;
  localparam int YW   = 4;
  localparam int EW   = 16 + 1 + XW + YW + WW;

  logic          clk = 1'b0;
  logic          rst, frame_start, in_valid;
  logic [PW-1:0] in_data;
  logic          out_valid, frame_done;
  logic [WW-1:0] out_window;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  // clock / reset
  always #5 clk = ~clk;

  line_window3x3 #(.BITWIDTH(8), .COLS(COLS), .ROWS(ROWS)) dut (
    .clkMain(clk), .rstMain(rst), .frame_start(frame_start), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_window(out_window),
    .out_x(out_x), .out_y(out_y), .frame_done(frame_done)
  );

  int   edge_cnt = 0;
  logic acc_seen = 1'b1, rst_seen = 1'b1;
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    acc_seen <= in_valid;
    rst_seen <= rst;
  end

  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0, n_bad = 0;
  logic [WW-1:0] cap_win [64];
  logic [XW-1:0] cap_x [64];
  logic [YW-1:0] cap_y [64];
  logic          cap_fd [64];
  int            cap_n = 0;
  int            tx = 0, ty = 0;
  logic          gap_mode = 1'b0;

  function automatic logic [WW-1:0] pack9(input int v [9]);
    logic [WW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = {3{8'(v[k])}};
    return w;
  endfunction

  function automatic logic [WW-1:0] model_win(input int x, input int y);
    int v [9];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) v[r*3+c] = (y - 2 + r) * COLS + (x - 2 + c);
    return pack9(v);
  endfunction

  // scoreboard monitor
  logic [EW-1:0] mon_e, mon_got;
  logic [WW-1:0] prev_win;
  logic [XW-1:0] prev_x;
  logic [YW-1:0] prev_y;
  logic          prev_ov = 1'b0;
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_valid: cycle=%0d x=%0d y=%0d, required no output", edge_cnt, out_x, out_y);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_got = {16'(edge_cnt), frame_done, out_x, out_y, out_window};
        if (mon_got !== mon_e) begin
          n_bad++;
          $display("FAIL window: got cyc=%0d fd=%0b x=%0d y=%0d win=%h, required cyc=%0d fd=%0b x=%0d y=%0d win=%h",
                   mon_got[EW-1 -: 16], mon_got[EW-17], mon_got[WW+YW +: XW], mon_got[WW +: YW], mon_got[WW-1:0],
                   mon_e[EW-1 -: 16], mon_e[EW-17], mon_e[WW+YW +: XW], mon_e[WW +: YW], mon_e[WW-1:0]);
        end
      end
      if (cap_n < 64) begin
        cap_win[cap_n] = out_window;
        cap_x[cap_n]   = out_x;
        cap_y[cap_n]   = out_y;
        cap_fd[cap_n]  = frame_done;
      end
      cap_n++;
      if (gap_mode) begin
        n_cmp++;
        if (prev_ov) begin
          n_bad++;
          $display("FAIL consecutive_valid: out_valid high on back-to-back cycles at cycle %0d, required isolated pulses", edge_cnt);
        end
      end
    end else begin
      n_cmp++;
      if (frame_done !== 1'b0) begin
        n_bad++;
        $display("FAIL frame_done_alone: frame_done=%b without out_valid at cycle %0d, required 0", frame_done, edge_cnt);
      end
      if (acc_seen === 1'b0 && rst_seen === 1'b0) begin
        n_cmp++;
        if (out_window !== prev_win || out_x !== prev_x || out_y !== prev_y) begin
          n_bad++;
          $display("FAIL hold: idle cycle %0d changed x=%0d y=%0d win=%h, required x=%0d y=%0d win=%h",
                   edge_cnt, out_x, out_y, out_window, prev_x, prev_y, prev_win);
        end
      end
    end
    prev_win = out_window;
    prev_x   = out_x;
    prev_y   = out_y;
    prev_ov  = out_valid;
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  // driver tasks
  task automatic send(input logic v, input logic fs, input int ngap);
    in_valid    = v;
    frame_start = fs;
    if (fs) begin
      tx = 0;
      ty = 0;
    end
    in_data = v ? {3{8'(ty * COLS + tx)}} : PW'($urandom);
    if (v) begin
      if (tx >= 2 && ty >= 2)
        exp_q.push_back({16'(edge_cnt + 1), (tx == COLS-1 && ty == ROWS-1), 4'(tx - 1), 4'(ty - 1), model_win(tx, ty)});
      if (tx == COLS - 1) begin
        tx = 0;
        ty = (ty == ROWS - 1) ? 0 : ty + 1;
      end else begin
        tx = tx + 1;
      end
    end
    @(posedge clk); #1;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    repeat (ngap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_pixels(input int n, input int mode);
    for (int i = 0; i < n; i++)
      send(1'b1, 1'b0, (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(1, 3));
  endtask

  task automatic do_reset(input int cycles);
    rst         = 1'b1;
    in_valid    = 1'b1;
    frame_start = 1'($urandom_range(0, 1));
    in_data     = PW'($urandom);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk("reset_outputs", {out_valid, frame_done, out_x, out_y, out_window}, '0);
    end
    rst         = 1'b0;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    tx = 0;
    ty = 0;
  endtask

  task automatic settle_and_check(input string nm, input int total);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    chk({nm, "_pulse_count"}, cap_n, total);
  endtask

  // Hand-derived windows of one full 8x6 frame, starting at capture index base.
  task automatic check_frame_caps(input string nm, input int base);
    int a [9];
    a = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    chk({nm, "_first_win"}, cap_win[base], pack9(a));
    chk({nm, "_first_xy"}, {cap_x[base], cap_y[base]}, {4'd1, 4'd1});
    a = '{16, 17, 18, 24, 25, 26, 32, 33, 34};
    chk({nm, "_rowwrap_win"}, cap_win[base+12], pack9(a));
    chk({nm, "_rowwrap_xy"}, {cap_x[base+12], cap_y[base+12]}, {4'd1, 4'd3});
    a = '{29, 30, 31, 37, 38, 39, 45, 46, 47};
    chk({nm, "_last_win"}, cap_win[base+23], pack9(a));
    chk({nm, "_last_done"}, cap_fd[base+23], 1'b1);
    chk({nm, "_last_xy"}, {cap_x[base+23], cap_y[base+23]}, {4'd6, 4'd4});
  endtask

  initial begin
    rst = 1'b0; frame_start = 1'b0; in_valid = 1'b0; in_data = '0;
    do_reset(3);

    cap_n = 0;
    send_pixels(48, 0);
    send_pixels(48, 0);
    settle_and_check("contig_two_frames", 48);
    check_frame_caps("frame1", 0);
    check_frame_caps("frame2", 24);

    cap_n = 0;
    gap_mode = 1'b1;
    send_pixels(48, 1);
    settle_and_check("alt_gaps", 24);
    check_frame_caps("alt_gaps", 0);

    cap_n = 0;
    send_pixels(48, 2);
    settle_and_check("rand_gaps", 24);
    check_frame_caps("rand_gaps", 0);
    gap_mode = 1'b0;

    cap_n = 0;
    send_pixels(28, 0);
    send(1'b1, 1'b1, 0);
    send_pixels(47, 0);
    settle_and_check("frame_start_mid", 32);
    check_frame_caps("frame_start_mid", 8);

    cap_n = 0;
    send_pixels(20, 0);
    do_reset(2);
    send(1'b0, 1'b0, 2);
    send_pixels(48, 0);
    settle_and_check("reset_mid", 26);
    check_frame_caps("reset_mid", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
